// File: rtl/chess_defs.sv
// Shared chess board definitions: default board geometry, cursor FSM states
// and the piece/colour codes used by the game logic.
package chess_defs;

  localparam int DEF_COLS   = 8;
  localparam int DEF_ROWS   = 8;
  localparam int DEF_ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECTED = 2'd1,
    REQUEST  = 2'd2
  } sel_state_e;

  localparam logic [2:0] PIECE_EMPTY  = 3'd0;
  localparam logic [2:0] PIECE_PAWN   = 3'd1;
  localparam logic [2:0] PIECE_KNIGHT = 3'd2;
  localparam logic [2:0] PIECE_BISHOP = 3'd3;
  localparam logic [2:0] PIECE_ROOK   = 3'd4;
  localparam logic [2:0] PIECE_QUEEN  = 3'd5;
  localparam logic [2:0] PIECE_KING   = 3'd6;

  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  // Hold-counter width that covers both the first delay and the repeat period.
  function automatic int cnt_width(int delay, int rate);
    int m;
    m = (delay > rate) ? delay : rate;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cursor_ctrl_if.sv
// Move request handshake between the cursor controller (master) and game logic.
interface cursor_ctrl_if #(parameter int ADDR_W = chess_defs::DEF_ADDR_W);
  logic              move_valid;
  logic              move_ready;
  logic [ADDR_W-1:0] move_from;
  logic [ADDR_W-1:0] move_to;

  modport master (output move_valid, move_from, move_to, input move_ready);
  modport slave  (input move_valid, move_from, move_to, output move_ready);
endinterface

// File: rtl/btn_repeat.sv
// Press-edge detector with hold-to-repeat; emits a single-cycle step pulse per
// press and per repeat interval while the button remains the active direction.
module btn_repeat
  import chess_defs::*;
#(
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic btn,
  input  logic enable,
  input  logic active,
  output logic step
);
  localparam int CNT_W = cnt_width(REPEAT_DELAY, REPEAT_RATE);

  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rep_q, rep_d;
  logic             press;
  logic             fire;

  assign press = btn & ~prev_q;
  assign step  = enable & (press | fire);

  // NOTE: every variable assigned here gets a default first, so no path leaves it holding state (no latch).
  always_comb begin
    cnt_d = '0;
    rep_d = 1'b0;
    fire  = 1'b0;
    if (REPEAT_DELAY != 0 && enable && active && btn) begin
      if (press) begin
        cnt_d = CNT_W'(1);
      end else if ((!rep_q && cnt_q == CNT_W'(REPEAT_DELAY)) ||
                   ( rep_q && cnt_q == CNT_W'(REPEAT_RATE))) begin
        fire  = 1'b1;
        rep_d = 1'b1;
        cnt_d = CNT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        rep_d = rep_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  // prev resets high so a button held through reset release is not a press.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      prev_q <= 1'b1;
      cnt_q  <= '0;
      rep_q  <= 1'b0;
    end else begin
      prev_q <= btn;
      cnt_q  <= cnt_d;
      rep_q  <= rep_d;
    end
  end
endmodule

// File: rtl/cursor_ctrl.sv
// Board cursor, square selection and move-request generator driven by the five
// debounced push-buttons; feeds game_logic's move validation.
module cursor_ctrl
  import chess_defs::*;
#(
  parameter int COLS         = DEF_COLS,
  parameter int ROWS         = DEF_ROWS,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int WRAP         = 0,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int INIT_ROW     = 6,
  parameter int INIT_COL     = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              BtnU,
  input  logic              BtnD,
  input  logic              BtnL,
  input  logic              BtnR,
  input  logic              BtnC,
  cursor_ctrl_if.master     move_if,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic [ADDR_W-1:0] selected_addr,
  output logic              hilite_selected_square
);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  sel_state_e        state_q;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] sel_q, from_q, to_q;
  logic              hil_q, mv_q;
  logic [3:0]        btn_dir, active, step;
  logic              c_press;
  logic              frozen;

  assign btn_dir = {BtnR, BtnL, BtnD, BtnU};
  assign frozen  = (state_q == REQUEST);

  // Only the highest-priority held direction may accumulate hold time.
  always_comb begin
    active = 4'b0000;
    if      (BtnU) active[0] = 1'b1;
    else if (BtnD) active[1] = 1'b1;
    else if (BtnL) active[2] = 1'b1;
    else if (BtnR) active[3] = 1'b1;
  end

  for (genvar i = 0; i < 4; i++) begin : g_dir
    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dir (
      .CLK(CLK), .RESET(RESET), .btn(btn_dir[i]), .enable(!frozen),
      .active(active[i]), .step(step[i])
    );
  end

  btn_repeat #(.REPEAT_DELAY(0), .REPEAT_RATE(1)) u_center (
    .CLK(CLK), .RESET(RESET), .btn(BtnC), .enable(1'b1),
    .active(1'b0), .step(c_press)
  );

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (step[0]) begin
      if (row_q == '0) row_d = (WRAP != 0) ? ROW_W'(ROWS - 1) : row_q;
      else             row_d = row_q - ROW_W'(1);
    end else if (step[1]) begin
      if (row_q == ROW_W'(ROWS - 1)) row_d = (WRAP != 0) ? '0 : row_q;
      else                           row_d = row_q + ROW_W'(1);
    end else if (step[2]) begin
      if (col_q == '0) col_d = (WRAP != 0) ? COL_W'(COLS - 1) : col_q;
      else             col_d = col_q - COL_W'(1);
    end else if (step[3]) begin
      if (col_q == COL_W'(COLS - 1)) col_d = (WRAP != 0) ? '0 : col_q;
      else                           col_d = col_q + COL_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      row_q <= ROW_W'(INIT_ROW);
      col_q <= COL_W'(INIT_COL);
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign cursor_addr = ADDR_W'(int'(row_q) * COLS + int'(col_q));

  // The FSM sees the pre-step cursor when C and a direction arrive together.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      sel_q   <= '0;
      hil_q   <= 1'b0;
      mv_q    <= 1'b0;
      from_q  <= '0;
      to_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (c_press) begin
          sel_q   <= cursor_addr;
          hil_q   <= 1'b1;
          state_q <= SELECTED;
        end
        SELECTED: if (c_press) begin
          if (cursor_addr == sel_q) begin
            hil_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            from_q  <= sel_q;
            to_q    <= cursor_addr;
            mv_q    <= 1'b1;
            state_q <= REQUEST;
          end
        end
        REQUEST: if (mv_q && move_if.move_ready) begin
          mv_q    <= 1'b0;
          hil_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign selected_addr          = sel_q;
  assign hilite_selected_square = hil_q;
  assign move_if.move_valid     = mv_q;
  assign move_if.move_from      = from_q;
  assign move_if.move_to        = to_q;
endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl on three board configurations; accepted moves
// are scored against a queue of expected (from, to) pairs.
module tb_cursor_ctrl;
  localparam logic [4:0] M_U = 5'b00001;
  localparam logic [4:0] M_D = 5'b00010;
  localparam logic [4:0] M_L = 5'b00100;
  localparam logic [4:0] M_R = 5'b01000;
  localparam logic [4:0] M_C = 5'b10000;

  typedef struct {
    logic [5:0] from;
    logic [5:0] to;
  } move_t;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b0;
  logic [4:0] btn [3];
  logic [5:0] cur [3];
  logic [5:0] sel [3];
  logic       hil [3];
  move_t      exp_q[$];
  int         total = 0;
  int         bad   = 0;

  always #5 CLK = ~CLK;

  cursor_ctrl_if #(.ADDR_W(6)) if_a ();
  cursor_ctrl_if #(.ADDR_W(6)) if_b ();
  cursor_ctrl_if #(.ADDR_W(6)) if_c ();

  // 8x8 saturating with a short repeat, 8x8 wrapping, 5x3 saturating
  cursor_ctrl #(.WRAP(0), .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut_a (
    .CLK(CLK), .RESET(RESET), .BtnU(btn[0][0]), .BtnD(btn[0][1]), .BtnL(btn[0][2]),
    .BtnR(btn[0][3]), .BtnC(btn[0][4]), .move_if(if_a), .cursor_addr(cur[0]),
    .selected_addr(sel[0]), .hilite_selected_square(hil[0]));

  cursor_ctrl #(.WRAP(1), .REPEAT_DELAY(0), .REPEAT_RATE(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .BtnU(btn[1][0]), .BtnD(btn[1][1]), .BtnL(btn[1][2]),
    .BtnR(btn[1][3]), .BtnC(btn[1][4]), .move_if(if_b), .cursor_addr(cur[1]),
    .selected_addr(sel[1]), .hilite_selected_square(hil[1]));

  cursor_ctrl #(.COLS(5), .ROWS(3), .WRAP(0), .REPEAT_DELAY(0), .REPEAT_RATE(1),
                .INIT_ROW(0), .INIT_COL(0)) dut_c (
    .CLK(CLK), .RESET(RESET), .BtnU(btn[2][0]), .BtnD(btn[2][1]), .BtnL(btn[2][2]),
    .BtnR(btn[2][3]), .BtnC(btn[2][4]), .move_if(if_c), .cursor_addr(cur[2]),
    .selected_addr(sel[2]), .hilite_selected_square(hil[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic press(input int d, input logic [4:0] m);
    btn[d] = m;
    tick();
    btn[d] = 5'b0;
    tick();
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
  endtask

  // Monitor: every accepted move must match the oldest expected one.
  always @(negedge CLK) begin
    move_t e;
    if (if_a.move_valid && if_a.move_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL move_unexpected: got from=%0d to=%0d expected none",
                 if_a.move_from, if_a.move_to);
      end else begin
        e = exp_q.pop_front();
        check("move_from", 32'(if_a.move_from), 32'(e.from));
        check("move_to", 32'(if_a.move_to), 32'(e.to));
      end
    end
  end

  initial begin
    int rep_exp [10] = '{44, 44, 44, 44, 36, 36, 28, 28, 20, 20};
    for (int i = 0; i < 3; i++) btn[i] = 5'b0;
    if_a.move_ready = 1'b0;
    if_b.move_ready = 1'b0;
    if_c.move_ready = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    tick();

    check("rst_cursor_a", 32'(cur[0]), 52);
    check("rst_sel_a", 32'(sel[0]), 0);
    check("rst_hilite_a", 32'(hil[0]), 0);
    check("rst_valid_a", 32'(if_a.move_valid), 0);
    check("rst_from_a", 32'(if_a.move_from), 0);
    check("rst_to_a", 32'(if_a.move_to), 0);
    check("rst_cursor_b", 32'(cur[1]), 52);
    check("rst_cursor_c", 32'(cur[2]), 0);

    // Hold U for 10 cycles: steps at cycles 0, 4, 6, 8
    btn[0] = M_U;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("repeat_%0d", k), 32'(cur[0]), 32'(rep_exp[k]));
    end
    btn[0] = 5'b0;
    tick();
    check("repeat_release", 32'(cur[0]), 20);

    // U held on dut_b across reset release is not a press
    btn[1] = M_U;
    RESET  = 1'b0;
    tick();
    RESET  = 1'b1;
    tick();
    tick();
    tick();
    check("held_thru_reset", 32'(cur[1]), 52);
    check("reset_cursor_a", 32'(cur[0]), 52);
    btn[1] = 5'b0;
    tick();
    check("held_release", 32'(cur[1]), 52);

    // Saturating sweep to h8
    press(0, M_D);                           check("sweep_d1", 32'(cur[0]), 60);
    press(0, M_D);                           check("sweep_d_edge", 32'(cur[0]), 60);
    for (int i = 0; i < 4; i++) press(0, M_L); check("sweep_l4", 32'(cur[0]), 56);
    press(0, M_L);                           check("sweep_l_edge", 32'(cur[0]), 56);
    for (int i = 0; i < 7; i++) press(0, M_U); check("sweep_u7", 32'(cur[0]), 0);
    press(0, M_U);                           check("sweep_u_edge", 32'(cur[0]), 0);
    for (int i = 0; i < 7; i++) press(0, M_R); check("sweep_r7", 32'(cur[0]), 7);
    press(0, M_R);                           check("sweep_r_edge", 32'(cur[0]), 7);

    // Wrap board
    press(1, M_D);
    for (int i = 0; i < 4; i++) press(1, M_L);
    check("wrap_a1", 32'(cur[1]), 56);
    press(1, M_L);       check("wrap_left", 32'(cur[1]), 63);
    press(1, M_D);       check("wrap_down", 32'(cur[1]), 7);
    press(1, M_U);       check("wrap_up", 32'(cur[1]), 63);
    press(1, M_U | M_R); check("prio_u_over_r", 32'(cur[1]), 55);
    press(1, M_L | M_D); check("prio_d_over_l", 32'(cur[1]), 63);

    // 5x3 board
    for (int i = 0; i < 6; i++) press(2, M_R); check("ns_right", 32'(cur[2]), 4);
    for (int i = 0; i < 4; i++) press(2, M_D); check("ns_down", 32'(cur[2]), 14);

    // Select / request / accept
    do_reset();
    press(0, M_C);
    check("sel_hilite", 32'(hil[0]), 1);
    check("sel_addr", 32'(sel[0]), 52);
    check("sel_no_valid", 32'(if_a.move_valid), 0);
    press(0, M_U);
    check("sel_step", 32'(cur[0]), 44);
    exp_q.push_back('{from: 6'd52, to: 6'd44});
    press(0, M_C);
    check("req_valid", 32'(if_a.move_valid), 1);
    check("req_from", 32'(if_a.move_from), 52);
    check("req_to", 32'(if_a.move_to), 44);
    press(0, M_U);
    press(0, M_C);
    tick();
    check("stall_valid", 32'(if_a.move_valid), 1);
    check("stall_from", 32'(if_a.move_from), 52);
    check("stall_to", 32'(if_a.move_to), 44);
    check("stall_cursor", 32'(cur[0]), 44);
    check("stall_hilite", 32'(hil[0]), 1);
    if_a.move_ready = 1'b1;
    tick();
    check("accept_valid", 32'(if_a.move_valid), 0);
    check("accept_hilite", 32'(hil[0]), 0);
    tick();
    check("idle_ready_valid", 32'(if_a.move_valid), 0);
    check("idle_ready_hilite", 32'(hil[0]), 0);
    if_a.move_ready = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 0);

    // Deselect on the same square
    press(0, M_C);
    check("desel_on", 32'(hil[0]), 1);
    check("desel_addr", 32'(sel[0]), 44);
    press(0, M_C);
    check("desel_off", 32'(hil[0]), 0);
    check("desel_no_valid", 32'(if_a.move_valid), 0);

    // C with L: selection takes the pre-step square, the step still happens
    press(0, M_C | M_L);
    check("cdir_sel", 32'(sel[0]), 44);
    check("cdir_cursor", 32'(cur[0]), 43);
    press(0, M_C);
    check("req2_valid", 32'(if_a.move_valid), 1);
    check("req2_to", 32'(if_a.move_to), 43);

    // Asynchronous reset during a pending request, no clock edge in between
    RESET = 1'b0;
    #1;
    check("async_valid", 32'(if_a.move_valid), 0);
    check("async_hilite", 32'(hil[0]), 0);
    check("async_cursor", 32'(cur[0]), 52);
    tick();
    RESET = 1'b1;
    tick();
    check("post_rst_cursor", 32'(cur[0]), 52);
    check("post_rst_valid", 32'(if_a.move_valid), 0);
    check("final_queue", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
